jtag_tap_controller: RTL and testbench
======================================

Name: jtag_tap_controller

Overview:
IEEE 1149.1-style TAP controller that sits directly downstream of shift_register.
- Drives shift_register's load and shift timing from the JTAG pins.
- Consumes its serial output bit.
- Presents it on TDO, alongside the IR, BYPASS and IDCODE registers.
- clk is used as TCK; all state advances on posedge clk.

Parameters:
IR_LENGTH, 4, instruction register width (>=2)
IDCODE_VALUE, 32'h1234_5001, value captured by IDCODE (bit 0 must be 1)
SAMPLE_OPCODE, 4'b0010, opcode selecting the external SoC capture chain

Ports:
clk  input  1  TCK; all flops on posedge
rst  input  1  asynchronous, active-high reset
tms  input  1  test mode select, sampled at posedge clk
tdi  input  1  serial test data in
ext_tdo  input  1  serial bit from the external capture shift register (shift_register jtagOutput)
ext_load  output  1  load strobe to external shift register
ext_shift  output  1  shift enable to external shift register
tdo  output  1  serial test data out
tdo_en  output  1  high while shifting IR or DR
ir_out  output  IR_LENGTH  current (updated) instruction
tap_state  output  4  current TAP state encoding

Behaviour:
- Reset (async, rst=1):
  - State = TEST_LOGIC_RESET (0).
  - ir_out = IDCODE opcode 4'b0001.
  - All shift registers cleared.
  - ext_load=0, ext_shift=0, tdo=0, tdo_en=0.
- State encodings:
  - TLR=0, RTI=1, SEL_DR=2, CAP_DR=3, SH_DR=4, EX1_DR=5, PA_DR=6, EX2_DR=7, UPD_DR=8.
  - SEL_IR=9, CAP_IR=10, SH_IR=11, EX1_IR=12, PA_IR=13, EX2_IR=14, UPD_IR=15.
- Transitions (tms=0 / tms=1):
  - TLR->RTI/TLR; RTI->RTI/SEL_DR; SEL_DR->CAP_DR/SEL_IR; SEL_IR->CAP_IR/TLR.
  - CAP_x->SH_x/EX1_x; SH_x->SH_x/EX1_x; EX1_x->PA_x/UPD_x.
  - PA_x->PA_x/EX2_x; EX2_x->SH_x/UPD_x; UPD_x->RTI/SEL_DR.
- Five consecutive tms=1 edges from any state reach TLR.
- Entering or sitting in TLR forces ir_out = 4'b0001 on that edge.
- Decoding of ir_out:
  - 4'b1111 = BYPASS, 4'b0001 = IDCODE, SAMPLE_OPCODE = SAMPLE.
  - Any other code behaves as BYPASS.
- IR path:
  - Edge leaving CAP_IR: ir_shift loads {zeros, 2'b01}.
  - Each edge in SH_IR: ir_shift shifts right; tdi enters the MSB.
  - Edge in UPD_IR: ir_out <= ir_shift.
- DR path, edge in CAP_DR:
  - BYPASS: bypass reg <= 0.
  - IDCODE: id_shift <= IDCODE_VALUE.
- DR path, each edge in SH_DR:
  - The selected register shifts right with tdi into the MSB.
  - The bypass register is 1 bit.
- ext_load:
  - Combinational, 1 only while state==CAP_DR and instruction is SAMPLE.
  - The external register therefore loads on the edge leaving CAP_DR.
- ext_shift:
  - Combinational, 1 only while state==SH_DR and instruction is SAMPLE.
  - 0 in PA_DR and EX states, so shifting pauses.
- tdo and tdo_en, combinational:
  - In SH_IR: tdo = ir_shift[0].
  - In SH_DR: tdo = bypass / id_shift[0] / ext_tdo according to the instruction.
  - Otherwise tdo=0.
  - tdo_en = (state==SH_IR || state==SH_DR).
- Boundaries:
  - Instruction changes only at UPD_IR, so a DR scan in progress never changes source.
  - Reset mid-scan aborts the scan; any partial shift contents are discarded.
  - Exactly one-cycle ext_load per CAP_DR visit.
- Target size: ~200 lines; single always block for state, separate datapath registers.

Test Plan:
- rst pulse, then tms=1 x5 -> tap_state=0, ir_out=4'b0001, ext_load=0, ext_shift=0, tdo_en=0.
- From RTI, tms 1,0,0 then 32 SH_DR edges with tdi=0 -> tdo sequence reproduces 32'h1234_5001 LSB first (first bit 1).
- IR scan 1,1,0,0 then shift 4'b1111 -> during shift tdo shows captured 1,0,0,0; after UPD_IR ir_out=4'b1111.
- BYPASS DR scan with tdi pattern 1,0,1,1 -> tdo = 0,1,0,1 (one-bit delay, leading capture 0).
- Load SAMPLE (4'b0010), DR scan -> ext_load=1 for exactly one cycle in CAP_DR; ext_shift=1 only in SH_DR; tdo tracks ext_tdo each cycle; ext_shift=0 during PA_DR.
- Assert rst asynchronously mid SH_IR -> tap_state=0 and ir_out=4'b0001 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/jtag_tap_controller_if.sv
// JTAG pin bundle plus the serial handshake to the external capture chain.
// The master side drives TMS/TDI and the external chain's serial bit.
// The slave side is the TAP controller.
interface jtag_tap_controller_if #(
    parameter int IR_LENGTH = 4
);
    logic                 tms;
    logic                 tdi;
    logic                 ext_tdo;
    logic                 ext_load;
    logic                 ext_shift;
    logic                 tdo;
    logic                 tdo_en;
    logic [IR_LENGTH-1:0] ir_out;
    logic [3:0]           tap_state;

    modport master (
        output tms, tdi, ext_tdo,
        input  ext_load, ext_shift, tdo, tdo_en, ir_out, tap_state
    );

    modport slave (
        input  tms, tdi, ext_tdo,
        output ext_load, ext_shift, tdo, tdo_en, ir_out, tap_state
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1-style TAP controller.
// Holds IR, BYPASS and IDCODE locally and steers an external capture shift
// register (SAMPLE) through its load/shift strobes. clk is TCK.
module jtag_tap_controller #(
    parameter int                   IR_LENGTH     = 4,
    parameter logic [31:0]          IDCODE_VALUE  = 32'h1234_5001,
    parameter logic [IR_LENGTH-1:0] SAMPLE_OPCODE = IR_LENGTH'(2)
) (
    input  logic                  clk,
    input  logic                  rst,
    jtag_tap_controller_if.slave  jtag
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tapState_t;

    localparam logic [IR_LENGTH-1:0] IDCODE_OPCODE = IR_LENGTH'(1);
    localparam logic [IR_LENGTH-1:0] IR_CAPTURE    = IR_LENGTH'(2'b01);

    tapState_t            state, nextState;
    logic [IR_LENGTH-1:0] irShift, irReg;
    logic [31:0]          idShift;
    logic                 bypassReg;
    logic                 isIdcode, isSample;
    logic                 tdo, tdoEn, extLoad, extShift;

    // Unknown opcodes and the all-ones code both fall through to BYPASS.
    assign isIdcode = (irReg == IDCODE_OPCODE);
    assign isSample = (irReg == SAMPLE_OPCODE) && !isIdcode;

    // TAP state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TLR;
        else     state <= nextState;
    end

    // TAP next-state logic, driven purely by TMS.
    always_comb begin
        nextState = state;
        case (state)
            TLR:    nextState = jtag.tms ? TLR    : RTI;
            RTI:    nextState = jtag.tms ? SEL_DR : RTI;
            SEL_DR: nextState = jtag.tms ? SEL_IR : CAP_DR;
            CAP_DR: nextState = jtag.tms ? EX1_DR : SH_DR;
            SH_DR:  nextState = jtag.tms ? EX1_DR : SH_DR;
            EX1_DR: nextState = jtag.tms ? UPD_DR : PA_DR;
            PA_DR:  nextState = jtag.tms ? EX2_DR : PA_DR;
            EX2_DR: nextState = jtag.tms ? UPD_DR : SH_DR;
            UPD_DR: nextState = jtag.tms ? SEL_DR : RTI;
            SEL_IR: nextState = jtag.tms ? TLR    : CAP_IR;
            CAP_IR: nextState = jtag.tms ? EX1_IR : SH_IR;
            SH_IR:  nextState = jtag.tms ? EX1_IR : SH_IR;
            EX1_IR: nextState = jtag.tms ? UPD_IR : PA_IR;
            PA_IR:  nextState = jtag.tms ? EX2_IR : PA_IR;
            EX2_IR: nextState = jtag.tms ? UPD_IR : SH_IR;
            UPD_IR: nextState = jtag.tms ? SEL_DR : RTI;
            default: nextState = TLR;
        endcase
    end

    // IR shift stage: capture the fixed 01 pattern, then shift LSB-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  irShift <= '0;
        else if (state == CAP_IR) irShift <= IR_CAPTURE;
        else if (state == SH_IR)  irShift <= {jtag.tdi, irShift[IR_LENGTH-1:1]};
    end

    // Active instruction: only UPD_IR changes it, TLR forces IDCODE back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   irReg <= IDCODE_OPCODE;
        else if (nextState == TLR) irReg <= IDCODE_OPCODE;
        else if (state == UPD_IR)  irReg <= irShift;
    end

    // One-bit bypass path, captures 0 so the host sees a leading zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 bypassReg <= 1'b0;
        else if (!isIdcode && !isSample) begin
            if (state == CAP_DR)                 bypassReg <= 1'b0;
            else if (state == SH_DR)             bypassReg <= jtag.tdi;
        end
    end

    // IDCODE register, loaded in CAP_DR and shifted out LSB first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     idShift <= '0;
        else if (isIdcode) begin
            if (state == CAP_DR)     idShift <= IDCODE_VALUE;
            else if (state == SH_DR) idShift <= {jtag.tdi, idShift[31:1]};
        end
    end

    // Output mux and external chain strobes; all combinational on state.
    always_comb begin
        tdo      = 1'b0;
        tdoEn    = 1'b0;
        extLoad  = 1'b0;
        extShift = 1'b0;
        case (state)
            SH_IR: begin
                tdoEn = 1'b1;
                tdo   = irShift[0];
            end
            SH_DR: begin
                tdoEn    = 1'b1;
                extShift = isSample;
                if (isSample)      tdo = jtag.ext_tdo;
                else if (isIdcode) tdo = idShift[0];
                else               tdo = bypassReg;
            end
            CAP_DR:  extLoad = isSample;
            default: ;
        endcase
    end

    assign jtag.tdo       = tdo;
    assign jtag.tdo_en    = tdoEn;
    assign jtag.ext_load  = extLoad;
    assign jtag.ext_shift = extShift;
    assign jtag.ir_out    = irReg;
    assign jtag.tap_state = state;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Bench for jtag_tap_controller: directed scans plus a random TMS/TDI walk,
// compared against a queue-based model of the TAP.
module tb_jtag_tap_controller;

    localparam logic [31:0] IDV = 32'h1234_5001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtag_tap_controller_if #(.IR_LENGTH(4)) jif ();

    jtag_tap_controller #(
        .IR_LENGTH(4), .IDCODE_VALUE(IDV), .SAMPLE_OPCODE(4'b0010)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .jtag (jif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: TAP walk table, IR and DR contents as bit queues (front = LSB).
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int         mState;
    logic [3:0] mIr;
    bit         irQ[$];
    bit         drQ[$];

    function automatic void modelReset();
        mState = 0;
        mIr    = 4'b0001;
        irQ    = '{0, 0, 0, 0};
        drQ.delete();
    endfunction

    function automatic void modelEdge(input logic t, input logic d);
        int nxt;
        nxt = t ? nxt1[mState] : nxt0[mState];
        if (mState == 10) irQ = '{1, 0, 0, 0};
        if (mState == 11) begin
            void'(irQ.pop_front());
            irQ.push_back(d);
        end
        if (mState == 3) begin
            drQ.delete();
            if (mIr == 4'b0001) for (int i = 0; i < 32; i++) drQ.push_back(IDV[i]);
            else if (mIr != 4'b0010) drQ.push_back(1'b0);
        end
        if (mState == 4 && mIr != 4'b0010) begin
            void'(drQ.pop_front());
            drQ.push_back(d);
        end
        if (nxt == 0) mIr = 4'b0001;
        else if (mState == 15) for (int i = 0; i < 4; i++) mIr[i] = irQ[i];
        mState = nxt;
    endfunction

    function automatic logic expTdo();
        if (mState == 11) return irQ[0];
        if (mState == 4) begin
            if (mIr == 4'b0010) return jif.ext_tdo;
            return (drQ.size() > 0) ? drQ[0] : 1'b0;
        end
        return 1'b0;
    endfunction

    task automatic drive(input logic t, input logic d, input logic e);
        jif.tms     = t;
        jif.tdi     = d;
        jif.ext_tdo = e;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge(jif.tms, jif.tdi);
        @(negedge clk);
    endtask

    task automatic move(input logic t);
        drive(t, 1'($urandom), 1'($urandom));
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        modelReset();
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (jif.tap_state !== 4'd0 || jif.ir_out !== 4'b0001) begin
            failures++;
            $display("FAIL reset_state: state=%0d ir=%b want 0 0001", jif.tap_state, jif.ir_out);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) move(1'b1);
        drive(1'b1, 1'b0, 1'b0);
        checks++;
        if (jif.tap_state !== 4'd0 || jif.ir_out !== 4'b0001 || jif.ext_load !== 1'b0 ||
            jif.ext_shift !== 1'b0 || jif.tdo_en !== 1'b0 || jif.tdo !== 1'b0) begin
            failures++;
            $display("FAIL reset_tms5: state=%0d ir=%b ld=%b sh=%b en=%b tdo=%b want 0 0001 0 0 0 0",
                     jif.tap_state, jif.ir_out, jif.ext_load, jif.ext_shift, jif.tdo_en, jif.tdo);
        end
    endtask

    task automatic test_idcode();
        move(1'b0); move(1'b1); move(1'b0); move(1'b0);
        for (int i = 0; i < 32; i++) begin
            drive(i == 31, 1'($urandom), 1'($urandom));
            checks++;
            if (jif.tdo !== IDV[i] || jif.tdo !== expTdo() || jif.tdo_en !== 1'b1) begin
                failures++;
                $display("FAIL idcode_bit%0d: tdo=%b en=%b want %b 1", i, jif.tdo, jif.tdo_en, IDV[i]);
            end
            tick();
        end
        move(1'b1); move(1'b0);
        checks++;
        if (jif.tap_state !== 4'd1) begin
            failures++;
            $display("FAIL idcode_exit: state=%0d want 1", jif.tap_state);
        end
    endtask

    task automatic test_ir_scan(input logic [3:0] op);
        move(1'b1); move(1'b1); move(1'b0); move(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, op[i], 1'b0);
            checks++;
            if (jif.tdo !== (i == 0) || jif.tdo !== expTdo() || jif.tap_state !== 4'd11) begin
                failures++;
                $display("FAIL ir_capture_bit%0d: tdo=%b state=%0d want %b 11", i, jif.tdo, jif.tap_state, i == 0);
            end
            tick();
        end
        move(1'b1); move(1'b0);
        checks++;
        if (jif.ir_out !== op || jif.ir_out !== mIr) begin
            failures++;
            $display("FAIL ir_update: ir=%b want %b", jif.ir_out, op);
        end
    endtask

    task automatic test_bypass();
        logic [3:0] pat, want;
        pat  = 4'b1101;   // tdi 1,0,1,1 in order i=0..3
        want = 4'b1010;   // tdo 0,1,0,1
        move(1'b1); move(1'b0); move(1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, pat[i], 1'b0);
            checks++;
            if (jif.tdo !== want[i] || jif.tdo !== expTdo()) begin
                failures++;
                $display("FAIL bypass_bit%0d: tdo=%b want %b", i, jif.tdo, want[i]);
            end
            tick();
        end
        move(1'b1); move(1'b0);
    endtask

    task automatic test_sample();
        logic seq [16] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0};
        int loads = 0;
        int shifts = 0;
        test_ir_scan(4'b0010);
        move(1'b1); move(1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(seq[i], 1'($urandom), 1'($urandom));
            if (jif.ext_load === 1'b1) loads++;
            if (jif.ext_shift === 1'b1) shifts++;
            checks++;
            if (jif.ext_load !== (mState == 3) || jif.ext_shift !== (mState == 4) ||
                jif.tdo !== expTdo() || (mState == 4 && jif.tdo !== jif.ext_tdo)) begin
                failures++;
                $display("FAIL sample_cyc%0d: st=%0d ld=%b sh=%b tdo=%b ext=%b", i, jif.tap_state,
                         jif.ext_load, jif.ext_shift, jif.tdo, jif.ext_tdo);
            end
            if (mState == 6) begin
                checks++;
                if (jif.ext_shift !== 1'b0) begin
                    failures++;
                    $display("FAIL sample_pause: ext_shift=%b want 0", jif.ext_shift);
                end
            end
            tick();
        end
        checks++;
        if (loads != 1 || shifts != 8) begin
            failures++;
            $display("FAIL sample_counts: loads=%0d shifts=%0d want 1 8", loads, shifts);
        end
    endtask

    task automatic test_async_reset();
        move(1'b1); move(1'b1); move(1'b0); move(1'b0);
        move(1'b0); move(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (jif.tap_state !== 4'd0 || jif.ir_out !== 4'b0001 || jif.tdo_en !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: state=%0d ir=%b en=%b want 0 0001 0",
                     jif.tap_state, jif.ir_out, jif.tdo_en);
        end
        modelReset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, 1'($urandom), 1'($urandom));
            checks++;
            if (jif.tap_state !== 4'(mState) || jif.ir_out !== mIr || jif.tdo !== expTdo() ||
                jif.tdo_en !== (mState == 4 || mState == 11) ||
                jif.ext_load !== (mState == 3 && mIr == 4'b0010) ||
                jif.ext_shift !== (mState == 4 && mIr == 4'b0010)) begin
                failures++;
                $display("FAIL random_cyc%0d: st=%0d/%0d ir=%b/%b tdo=%b/%b en=%b ld=%b sh=%b",
                         i, jif.tap_state, mState, jif.ir_out, mIr, jif.tdo, expTdo(),
                         jif.tdo_en, jif.ext_load, jif.ext_shift);
            end
            tick();
        end
    endtask

    initial begin
        jif.tms = 1'b1; jif.tdi = 1'b0; jif.ext_tdo = 1'b0;
        @(negedge clk);
        test_reset();
        test_idcode();
        test_ir_scan(4'b1111);
        test_bypass();
        test_sample();
        test_async_reset();
        for (int i = 0; i < 5; i++) move(1'b1);
        move(1'b0);
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
